// File: rtl/onchip_mem_pkg.sv
// Shared constants and helpers for the dual-port on-chip memory.
// Parity storage is enabled by defining ONCHIP_MEM_PARITY_EN.
package onchip_mem_pkg;

  localparam int LAT_BASE   = 1;
  localparam int LANE_W     = 8;
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / LANE_W;

  // Parity bit that makes byte plus parity carry an even number of ones
  function automatic logic even_parity(input logic [LANE_W-1:0] b);
    return ^b;
  endfunction

  // Lanes set in be take data, the rest keep old; callers extend to MAX_DATA_W and truncate back
  function automatic logic [MAX_DATA_W-1:0] merge_lanes(input logic [MAX_DATA_W-1:0] old_w,
                                                        input logic [MAX_DATA_W-1:0] data_w,
                                                        input logic [MAX_BE_W-1:0]   be);
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[i*LANE_W +: LANE_W] = data_w[i*LANE_W +: LANE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/onchip_mem_rd_pipe.sv
// Per-port read response pipeline: valid/out-of-range tracking and optional output register.
// Parity error reporting is present when ONCHIP_MEM_PARITY_EN is defined.
module onchip_mem_rd_pipe
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OUTREG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              rd_acc,
  input  logic              in_rng,
  input  logic [DATA_W-1:0] ram_data,
`ifdef ONCHIP_MEM_PARITY_EN
  input  logic              perr_in,
  output logic              parity_err,
`endif
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  localparam int LAT = LAT_BASE + OUTREG;

  logic              vld_p0_q, vld_p0_d;
  logic              zero_p0_q, zero_p0_d;
  logic [DATA_W-1:0] data_p0;

  // stage p0: RAM output register; as the last stage its valid must not repeat across a stall
  always_comb begin
    if (en) vld_p0_d = rd_acc;
    else    vld_p0_d = (LAT > LAT_BASE) ? vld_p0_q : 1'b0;
    zero_p0_d = rd_acc ? ~in_rng : zero_p0_q;
    data_p0   = zero_p0_q ? '0 : ram_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0_q  <= 1'b0;
      zero_p0_q <= 1'b1;
    end else begin
      vld_p0_q  <= vld_p0_d;
      zero_p0_q <= zero_p0_d;
    end
  end

`ifdef ONCHIP_MEM_PARITY_EN
  logic err_p0;
  assign err_p0 = ~zero_p0_q & perr_in;
`endif

  if (LAT > LAT_BASE) begin : g_outreg
    logic              vld_p1_q, vld_p1_d;
    logic [DATA_W-1:0] data_p1_q, data_p1_d;
`ifdef ONCHIP_MEM_PARITY_EN
    logic              perr_p1_q, perr_p1_d;
`endif

    // stage p1: output register
    always_comb begin
      vld_p1_d  = en & vld_p0_q;
      data_p1_d = vld_p1_d ? data_p0 : data_p1_q;
`ifdef ONCHIP_MEM_PARITY_EN
      perr_p1_d = vld_p1_d & err_p0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_p1_q  <= 1'b0;
        data_p1_q <= '0;
`ifdef ONCHIP_MEM_PARITY_EN
        perr_p1_q <= 1'b0;
`endif
      end else begin
        vld_p1_q  <= vld_p1_d;
        data_p1_q <= data_p1_d;
`ifdef ONCHIP_MEM_PARITY_EN
        perr_p1_q <= perr_p1_d;
`endif
      end
    end

    assign readdata      = data_p1_q;
    assign readdatavalid = vld_p1_q;
`ifdef ONCHIP_MEM_PARITY_EN
    assign parity_err    = perr_p1_q;
`endif
  end else begin : g_direct
    assign readdata      = data_p0;
    assign readdatavalid = vld_p0_q;
`ifdef ONCHIP_MEM_PARITY_EN
    assign parity_err    = vld_p0_q & err_p0;
`endif
  end

endmodule

// File: rtl/arquitetura_onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slaves, byte lanes and pipelined read response.
// Define ONCHIP_MEM_PARITY_EN to store and check an even-parity bit per byte.
module arquitetura_onchip_memory_dp
  import onchip_mem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 8192,
  parameter int    ADDR_W    = 13,
  parameter int    OUTREG    = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reset_req,
  input  logic                     clken,
  input  logic                     a_chipselect,
  input  logic                     a_read,
  input  logic                     a_write,
  input  logic [ADDR_W-1:0]        a_address,
  input  logic [DATA_W/LANE_W-1:0] a_byteenable,
  input  logic [DATA_W-1:0]        a_writedata,
  output logic [DATA_W-1:0]        a_readdata,
  output logic                     a_readdatavalid,
  output logic                     a_waitrequest,
`ifdef ONCHIP_MEM_PARITY_EN
  output logic                     a_parity_err,
  output logic                     b_parity_err,
`endif
  input  logic                     b_chipselect,
  input  logic                     b_read,
  input  logic                     b_write,
  input  logic [ADDR_W-1:0]        b_address,
  input  logic [DATA_W/LANE_W-1:0] b_byteenable,
  input  logic [DATA_W-1:0]        b_writedata,
  output logic [DATA_W-1:0]        b_readdata,
  output logic                     b_readdatavalid,
  output logic                     b_waitrequest
);

  localparam int              BE_W    = DATA_W / LANE_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              en;
  logic              a_in_rng, b_in_rng;
  logic              a_rd_acc, b_rd_acc;
  logic              a_wr_acc, b_wr_acc, b_wr_eff;
  logic              wr_collide;
  logic [DATA_W-1:0] a_wdata_m;
  logic [BE_W-1:0]   a_be_m;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_ram_p0_q, b_ram_p0_q;

  // A same-address double write is folded into one port-A write: A lanes over B lanes
  always_comb begin
    en         = clken & ~reset_req;
    a_in_rng   = {1'b0, a_address} < DEPTH_L;
    b_in_rng   = {1'b0, b_address} < DEPTH_L;
    a_rd_acc   = en & a_chipselect & a_read & ~a_write;
    b_rd_acc   = en & b_chipselect & b_read & ~b_write;
    a_wr_acc   = en & a_chipselect & a_write & a_in_rng;
    b_wr_acc   = en & b_chipselect & b_write & b_in_rng;
    wr_collide = a_wr_acc & b_wr_acc & (a_address == b_address);
    b_wr_eff   = b_wr_acc & ~wr_collide;
    a_wdata_m  = a_writedata;
    a_be_m     = a_byteenable;
    if (wr_collide) begin
      a_wdata_m = DATA_W'(merge_lanes(MAX_DATA_W'(b_writedata), MAX_DATA_W'(a_writedata),
                                      MAX_BE_W'(a_byteenable)));
      a_be_m    = a_byteenable | b_byteenable;
    end
    a_waitrequest = ~clken | reset_req;
    b_waitrequest = ~clken | reset_req;
  end

`ifdef ONCHIP_MEM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
  logic [BE_W-1:0] a_par_p0_q, b_par_p0_q;
  logic            a_perr, b_perr;

  always_comb begin
    a_perr = 1'b0;
    b_perr = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      a_perr = a_perr | (even_parity(a_ram_p0_q[i*LANE_W +: LANE_W]) != a_par_p0_q[i]);
      b_perr = b_perr | (even_parity(b_ram_p0_q[i*LANE_W +: LANE_W]) != b_par_p0_q[i]);
    end
  end
`endif

  // stage p0 entry: byte-lane writes and registered reads (old data on read-during-write)
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (a_wr_acc && a_be_m[i]) begin
        mem[a_address][i*LANE_W +: LANE_W] <= a_wdata_m[i*LANE_W +: LANE_W];
`ifdef ONCHIP_MEM_PARITY_EN
        par_mem[a_address][i] <= even_parity(a_wdata_m[i*LANE_W +: LANE_W]);
`endif
      end
      if (b_wr_eff && b_byteenable[i]) begin
        mem[b_address][i*LANE_W +: LANE_W] <= b_writedata[i*LANE_W +: LANE_W];
`ifdef ONCHIP_MEM_PARITY_EN
        par_mem[b_address][i] <= even_parity(b_writedata[i*LANE_W +: LANE_W]);
`endif
      end
    end
    if (a_rd_acc) a_ram_p0_q <= mem[a_address];
    if (b_rd_acc) b_ram_p0_q <= mem[b_address];
`ifdef ONCHIP_MEM_PARITY_EN
    if (a_rd_acc) a_par_p0_q <= par_mem[a_address];
    if (b_rd_acc) b_par_p0_q <= par_mem[b_address];
`endif
  end

  onchip_mem_rd_pipe #(.DATA_W(DATA_W), .OUTREG(OUTREG)) u_pipe_a (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .rd_acc        (a_rd_acc),
    .in_rng        (a_in_rng),
    .ram_data      (a_ram_p0_q),
`ifdef ONCHIP_MEM_PARITY_EN
    .perr_in       (a_perr),
    .parity_err    (a_parity_err),
`endif
    .readdata      (a_readdata),
    .readdatavalid (a_readdatavalid)
  );

  onchip_mem_rd_pipe #(.DATA_W(DATA_W), .OUTREG(OUTREG)) u_pipe_b (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .rd_acc        (b_rd_acc),
    .in_rng        (b_in_rng),
    .ram_data      (b_ram_p0_q),
`ifdef ONCHIP_MEM_PARITY_EN
    .perr_in       (b_perr),
    .parity_err    (b_parity_err),
`endif
    .readdata      (b_readdata),
    .readdatavalid (b_readdatavalid)
  );

endmodule

// File: tb/tb_arquitetura_onchip_memory_dp.sv
// Directed bench: two instances (OUTREG=0 and OUTREG=1, DEPTH=6000) share one stimulus stream.
module tb_arquitetura_onchip_memory_dp;

  logic        clk = 1'b0;
  logic        reset, reset_req, clken;
  logic        a_cs, a_read, a_write, b_cs, b_read, b_write;
  logic [12:0] a_addr, b_addr;
  logic [3:0]  a_be, b_be;
  logic [31:0] a_wd, b_wd;
  logic [31:0] a_rd0, b_rd0, a_rd1, b_rd1;
  logic        a_v0, b_v0, a_v1, b_v1;
  logic        a_w0, b_w0, a_w1, b_w1;
`ifdef ONCHIP_MEM_PARITY_EN
  logic        a_pe0, b_pe0, a_pe1, b_pe1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arquitetura_onchip_memory_dp #(.DATA_W(32), .DEPTH(6000), .ADDR_W(13), .OUTREG(0)) u0 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .a_chipselect(a_cs), .a_read(a_read), .a_write(a_write), .a_address(a_addr),
    .a_byteenable(a_be), .a_writedata(a_wd), .a_readdata(a_rd0),
    .a_readdatavalid(a_v0), .a_waitrequest(a_w0),
`ifdef ONCHIP_MEM_PARITY_EN
    .a_parity_err(a_pe0), .b_parity_err(b_pe0),
`endif
    .b_chipselect(b_cs), .b_read(b_read), .b_write(b_write), .b_address(b_addr),
    .b_byteenable(b_be), .b_writedata(b_wd), .b_readdata(b_rd0),
    .b_readdatavalid(b_v0), .b_waitrequest(b_w0)
  );

  arquitetura_onchip_memory_dp #(.DATA_W(32), .DEPTH(6000), .ADDR_W(13), .OUTREG(1)) u1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .a_chipselect(a_cs), .a_read(a_read), .a_write(a_write), .a_address(a_addr),
    .a_byteenable(a_be), .a_writedata(a_wd), .a_readdata(a_rd1),
    .a_readdatavalid(a_v1), .a_waitrequest(a_w1),
`ifdef ONCHIP_MEM_PARITY_EN
    .a_parity_err(a_pe1), .b_parity_err(b_pe1),
`endif
    .b_chipselect(b_cs), .b_read(b_read), .b_write(b_write), .b_address(b_addr),
    .b_byteenable(b_be), .b_writedata(b_wd), .b_readdata(b_rd1),
    .b_readdatavalid(b_v1), .b_waitrequest(b_w1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    a_cs = 1'b0; a_read = 1'b0; a_write = 1'b0;
    b_cs = 1'b0; b_read = 1'b0; b_write = 1'b0;
  endtask

  task automatic wr(input logic pb, input logic [12:0] addr, input logic [31:0] data,
                    input logic [3:0] be);
    @(negedge clk);
    if (pb) begin
      b_cs = 1'b1; b_write = 1'b1; b_addr = addr; b_wd = data; b_be = be;
    end else begin
      a_cs = 1'b1; a_write = 1'b1; a_addr = addr; a_wd = data; a_be = be;
    end
    @(negedge clk);
    idle();
  endtask

  // One read; OUTREG=0 answers one cycle later, OUTREG=1 two cycles later
  task automatic rd(input logic pb, input logic [12:0] addr, input logic [31:0] exp,
                    input string tag);
    @(negedge clk);
    if (pb) begin
      b_cs = 1'b1; b_read = 1'b1; b_addr = addr;
    end else begin
      a_cs = 1'b1; a_read = 1'b1; a_addr = addr;
    end
    @(negedge clk);
    idle();
    check({tag, ".l1_valid"},  pb ? b_v0 : a_v0, 1);
    check({tag, ".l1_data"},   pb ? b_rd0 : a_rd0, exp);
    check({tag, ".l2_early"},  pb ? b_v1 : a_v1, 0);
    @(negedge clk);
    check({tag, ".l2_valid"},  pb ? b_v1 : a_v1, 1);
    check({tag, ".l2_data"},   pb ? b_rd1 : a_rd1, exp);
    check({tag, ".l1_single"}, pb ? b_v0 : a_v0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g0 [4];
    logic [31:0] g1 [4];
    int c0, c1;

    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    a_addr = '0; a_be = '0; a_wd = '0; b_addr = '0; b_be = '0; b_wd = '0;
    idle();
    repeat (2) @(negedge clk);
    check("rst_a_rd0", a_rd0, 0); check("rst_a_v0", a_v0, 0);
    check("rst_b_rd0", b_rd0, 0); check("rst_b_v0", b_v0, 0);
    check("rst_a_rd1", a_rd1, 0); check("rst_a_v1", a_v1, 0);
    check("rst_b_rd1", b_rd1, 0); check("rst_b_v1", b_v1, 0);
    check("wait_idle_a", a_w0, 0); check("wait_idle_b", b_w1, 0);
    clken = 1'b0; #1 check("wait_clken", a_w0, 1);
    clken = 1'b1; reset_req = 1'b1; #1 check("wait_rreq", b_w1, 1);
    reset_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    wr(1'b0, 13'd5, 32'hDEADBEEF, 4'hF);
    rd(1'b0, 13'd5, 32'hDEADBEEF, "single");

    wr(1'b1, 13'd5, 32'h11223344, 4'h5);
    rd(1'b0, 13'd5, 32'hDE22BE44, "lanes");

    // read-during-write across ports returns the old word
    @(negedge clk);
    a_cs = 1'b1; a_write = 1'b1; a_addr = 13'd5; a_wd = 32'hCAFEF00D; a_be = 4'hF;
    b_cs = 1'b1; b_read = 1'b1; b_addr = 13'd5;
    @(negedge clk);
    idle();
    check("rdw.l1_valid", b_v0, 1); check("rdw.l1_data", b_rd0, 32'hDE22BE44);
    @(negedge clk);
    check("rdw.l2_valid", b_v1, 1); check("rdw.l2_data", b_rd1, 32'hDE22BE44);
    rd(1'b1, 13'd5, 32'hCAFEF00D, "rdw_new");

    wr(1'b0, 13'd9, 32'h12345678, 4'hF);
    @(negedge clk);
    a_cs = 1'b1; a_write = 1'b1; a_addr = 13'd9; a_wd = 32'hAAAAAAAA; a_be = 4'h3;
    b_cs = 1'b1; b_write = 1'b1; b_addr = 13'd9; b_wd = 32'hBBBBBBBB; b_be = 4'h6;
    @(negedge clk);
    idle();
    rd(1'b1, 13'd9, 32'h12BBAAAA, "collide");

    // read together with write acts as a write only
    @(negedge clk);
    a_cs = 1'b1; a_read = 1'b1; a_write = 1'b1; a_addr = 13'd30; a_wd = 32'h55AA55AA; a_be = 4'hF;
    @(negedge clk);
    idle();
    check("rdwr.no_valid0", a_v0, 0);
    @(negedge clk);
    check("rdwr.no_valid1", a_v1, 0);
    rd(1'b0, 13'd30, 32'h55AA55AA, "rdwr_data");

    rd(1'b0, 13'd6000, 32'h0, "oor_a");
    rd(1'b1, 13'd8191, 32'h0, "oor_b");

    for (int i = 0; i < 4; i++) wr(i[0], 13'(20 + i), 32'(256 + i), 4'hF);
    c0 = 0; c1 = 0;
    fork
      begin
        repeat (14) begin
          @(negedge clk);
          if (a_v0) begin if (c0 < 4) g0[c0] = a_rd0; c0++; end
          if (a_v1) begin if (c1 < 4) g1[c1] = a_rd1; c1++; end
        end
      end
      begin
        @(negedge clk); a_cs = 1'b1; a_read = 1'b1; a_addr = 13'd20;
        @(negedge clk); a_addr = 13'd21;
        @(negedge clk); a_addr = 13'd22; clken = 1'b0;
        #1 check("stall.wait", a_w0, 1);
        @(negedge clk); @(negedge clk);
        @(negedge clk); clken = 1'b1;
        @(negedge clk); a_addr = 13'd23;
        @(negedge clk); idle();
      end
    join
    check("stall.count0", c0, 4); check("stall.count1", c1, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < c0) check($sformatf("stall.d0_%0d", i), g0[i], 32'(256 + i));
      if (i < c1) check($sformatf("stall.d1_%0d", i), g1[i], 32'(256 + i));
    end

    // reset while a read is in flight
    @(negedge clk); a_cs = 1'b1; a_read = 1'b1; a_addr = 13'd5;
    @(negedge clk); idle(); reset = 1'b1;
    #1;
    check("rstfl.a_rd0", a_rd0, 0); check("rstfl.a_v0", a_v0, 0);
    check("rstfl.a_rd1", a_rd1, 0); check("rstfl.a_v1", a_v1, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); check("rstfl.lost_v1", a_v1, 0); check("rstfl.lost_rd1", a_rd1, 0);
    rd(1'b0, 13'd5, 32'hCAFEF00D, "ram_kept");

    // reset_req freezes acceptance until released
    @(negedge clk); reset_req = 1'b1; a_cs = 1'b1; a_read = 1'b1; a_addr = 13'd21;
    #1 check("rreq.wait", a_w0, 1);
    @(negedge clk); check("rreq.hold_v0", a_v0, 0); check("rreq.hold_v1", a_v1, 0);
    reset_req = 1'b0;
    @(negedge clk); idle();
    check("rreq.v0", a_v0, 1); check("rreq.d0", a_rd0, 32'h101);
    @(negedge clk); check("rreq.v1", a_v1, 1); check("rreq.d1", a_rd1, 32'h101);

`ifdef ONCHIP_MEM_PARITY_EN
    rd(1'b0, 13'd5, 32'hCAFEF00D, "par_clean");
    u0.par_mem[5][0] = ~u0.par_mem[5][0];
    u1.par_mem[5][0] = ~u1.par_mem[5][0];
    @(negedge clk); a_cs = 1'b1; a_read = 1'b1; a_addr = 13'd5;
    @(negedge clk); idle();
    check("par.err0", a_pe0, 1); check("par.v0", a_v0, 1);
    @(negedge clk);
    check("par.err1", a_pe1, 1); check("par.err0_gone", a_pe0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
